// File: rtl/image_transpose.sv
// Ping-pong frame buffer that emits each image column-major (transposed).
// A 2-entry output FIFO with read credits keeps one pixel per cycle.
module image_transpose #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic [15:0]       In1_COUNT,
  input  logic              In1_SEND,
  output logic              In1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic [15:0]       Out1_COUNT,
  output logic              Out1_SEND,
  input  logic              Out1_RDY,
  input  logic              Out1_ACK
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(2 * N);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [DATA_W-1:0] mem [2*N];
  logic [1:0]        full;
  logic              wb;
  logic              rb;
  logic [CW-1:0]     wc;
  logic [CW-1:0]     rc;
  logic [RW-1:0]     wr;
  logic [RW-1:0]     rr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [1:0]        occ;
  logic              in_xfer;
  logic              w_eol;
  logic              w_last;
  logic              r_eoc;
  logic              r_last;
  logic              rd_issue;
  logic              pop;
  logic [2:0]        credit;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic [1:0]        set_v;
  logic [1:0]        clr_v;
  logic              unused_ok;

  assign unused_ok  = ^{In1_COUNT, Out1_ACK};
  assign Out1_COUNT = 16'h0001;

  assign In1_ACK = RESET & In1_SEND & ~full[wb];
  assign in_xfer = In1_ACK;
  assign w_eol   = wc == CW'(IMG_W - 1);
  assign w_last  = w_eol & (wr == RW'(IMG_H - 1));
  assign r_eoc   = rr == RW'(IMG_H - 1);
  assign r_last  = r_eoc & (rc == CW'(IMG_W - 1));

  assign pop       = RESET & (occ != 2'd0) & Out1_RDY;
  assign Out1_SEND = pop;
  assign Out1_DATA = q0;

  // Credit counts the slot freed by this cycle's pop.
  assign credit   = 3'(occ) + 3'(rd_valid) - 3'(pop);
  assign rd_issue = RESET & full[rb] & (credit < 3'd2);

  assign waddr = (wb ? AW'(N) : AW'(0))
               + AW'(wr) * AW'(IMG_W) + AW'(wc);
  assign raddr = (rb ? AW'(N) : AW'(0))
               + AW'(rr) * AW'(IMG_W) + AW'(rc);

  assign set_v = (in_xfer & w_last) ? (2'b01 << wb) : 2'b00;
  assign clr_v = (rd_issue & r_last) ? (2'b01 << rb) : 2'b00;

  always_ff @(posedge CLK) begin
    if (in_xfer) mem[waddr] <= In1_DATA;
    rd_data <= mem[raddr];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~clr_v) | set_v;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wb <= 1'b0;
      wc <= '0;
      wr <= '0;
    end else if (in_xfer) begin
      if (w_last) begin
        wb <= ~wb;
        wc <= '0;
        wr <= '0;
      end else if (w_eol) begin
        wc <= '0;
        wr <= wr + RW'(1);
      end else begin
        wc <= wc + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rb       <= 1'b0;
      rc       <= '0;
      rr       <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_issue;
      if (rd_issue) begin
        if (r_last) begin
          rb <= ~rb;
          rc <= '0;
          rr <= '0;
        end else if (r_eoc) begin
          rr <= '0;
          rc <= rc + CW'(1);
        end else begin
          rr <= rr + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      occ <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      unique case ({rd_valid, pop})
        2'b10: begin
          if (occ == 2'd0) q0 <= rd_data;
          else             q1 <= rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            q0 <= rd_data;
          end else begin
            q0 <= q1;
            q1 <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_transpose.sv
// Randomized bench for image_transpose (4x3 frames) with a
// queue-based transpose model and per-cycle output comparison.
module tb_image_transpose;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;

  logic          clk;
  logic          RESET;
  logic [DW-1:0] In1_DATA;
  logic [15:0]   In1_COUNT;
  logic          In1_SEND;
  logic          In1_ACK;
  logic [DW-1:0] Out1_DATA;
  logic [15:0]   Out1_COUNT;
  logic          Out1_SEND;
  logic          Out1_RDY;
  logic          Out1_ACK;

  image_transpose #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .CLK(clk), .RESET(RESET),
    .In1_DATA(In1_DATA), .In1_COUNT(In1_COUNT),
    .In1_SEND(In1_SEND), .In1_ACK(In1_ACK),
    .Out1_DATA(Out1_DATA), .Out1_COUNT(Out1_COUNT),
    .Out1_SEND(Out1_SEND), .Out1_RDY(Out1_RDY),
    .Out1_ACK(Out1_ACK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int last_acc = 0;
  int rdy_mode = 1;
  int fbuf[$];
  int expq[$];
  int got[$];
  int send_cyc[$];

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d",
               nm, act, req);
    end
  endtask

  // Model: collect a raster frame, emit it column-major.
  task automatic run_monitor();
    forever begin
      @(negedge clk);
      cyc_n++;
      chk("out_count", int'(Out1_COUNT), 1);
      if (!RESET) begin
        fbuf.delete();
        expq.delete();
      end else begin
        if (In1_SEND && In1_ACK) begin
          fbuf.push_back(int'(In1_DATA));
          last_acc = cyc_n;
          if (fbuf.size() == W * H) begin
            for (int c = 0; c < W; c++)
              for (int r = 0; r < H; r++)
                expq.push_back(fbuf[r*W+c]);
            fbuf.delete();
          end
        end
        if (Out1_SEND) begin
          chk("send_needs_rdy", int'(Out1_RDY), 1);
          if (expq.size() == 0) begin
            chk("unexpected_send", 1, 0);
          end else begin
            chk("out_data", int'(Out1_DATA),
                expq.pop_front());
          end
          got.push_back(int'(Out1_DATA));
          send_cyc.push_back(cyc_n);
        end
      end
    end
  endtask

  task automatic run_side();
    forever begin
      @(posedge clk);
      #1;
      In1_COUNT = 16'($urandom);
      Out1_ACK  = 1'($urandom);
      case (rdy_mode)
        0:       Out1_RDY = 1'b0;
        1:       Out1_RDY = 1'b1;
        default: Out1_RDY = 1'($urandom_range(1));
      endcase
    end
  endtask

  task automatic push_seq(input int base, input int n,
                          input int pct, input bit rnd,
                          output int drops);
    int k;
    int guard;
    k = 0;
    guard = 0;
    drops = 0;
    while (k < n && guard < 2000) begin
      In1_DATA = rnd ? DW'($urandom) : DW'(base + k);
      In1_SEND = ($urandom_range(99) < pct);
      @(negedge clk);
      if (In1_SEND && In1_ACK) k++;
      else if (In1_SEND) drops++;
      guard++;
      @(posedge clk);
      #1;
    end
    In1_SEND = 1'b0;
    if (k < n) chk("push_timeout", k, n);
  endtask

  task automatic wait_out(input int n, input int lim);
    int g;
    g = 0;
    while (got.size() < n && g < lim) begin
      @(posedge clk);
      g++;
    end
    if (got.size() < n) chk("out_timeout", got.size(), n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int drops;
    int t;
    int acc;
    int wt;
    RESET     = 1'b0;
    In1_DATA  = '0;
    In1_COUNT = '0;
    In1_SEND  = 1'b1;
    Out1_RDY  = 1'b1;
    Out1_ACK  = 1'b0;
    fork
      run_monitor();
      run_side();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ack", int'(In1_ACK), 0);
    chk("rst_send", int'(Out1_SEND), 0);
    chk("rst_data", int'(Out1_DATA), 0);
    chk("rst_count", int'(Out1_COUNT), 1);
    In1_SEND = 1'b0;
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;

    // Single frame 0..11 and its latency.
    got.delete();
    send_cyc.delete();
    push_seq(0, 12, 100, 1'b0, drops);
    t = last_acc;
    wait_out(12, 200);
    chk("latency", send_cyc[0] - t, 3);
    chk("lit0", got[0], 0);
    chk("lit1", got[1], 4);
    chk("lit2", got[2], 8);
    chk("lit3", got[3], 1);
    chk("lit11", got[11], 11);

    // Three frames streaming back to back.
    got.delete();
    send_cyc.delete();
    push_seq(0, 36, 100, 1'b1, drops);
    wait_out(36, 200);
    chk("stream_drops", drops, 0);
    chk("stream_span", send_cyc[35] - send_cyc[0], 35);

    // Output stalled: both banks fill up.
    rdy_mode = 0;
    @(posedge clk);
    #2;
    got.delete();
    acc = 0;
    In1_SEND = 1'b1;
    for (int i = 0; i < 40; i++) begin
      In1_DATA = DW'(acc);
      @(negedge clk);
      if (In1_ACK) acc++;
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    chk("stall_accepted", acc, 24);
    chk("stall_ack_low", int'(In1_ACK), 0);
    chk("stall_no_out", got.size(), 0);
    chk("stall_head", int'(Out1_DATA), expq[0]);
    rdy_mode = 1;
    @(posedge clk);
    #2;
    wt = 0;
    In1_DATA = DW'(24);
    In1_SEND = 1'b1;
    while (wt < 40) begin
      @(negedge clk);
      if (In1_ACK) break;
      wt++;
      @(posedge clk);
      #2;
    end
    chk("ack_return_ok", int'(wt <= 15), 1);
    @(posedge clk);
    #1;
    push_seq(25, 11, 100, 1'b0, drops);
    wait_out(36, 300);

    // Random backpressure and random sends.
    rdy_mode = 2;
    got.delete();
    push_seq(0, 24, 70, 1'b1, drops);
    wait_out(24, 1000);
    rdy_mode = 1;

    // Reset mid-frame with a whole frame buffered.
    rdy_mode = 0;
    push_seq(0, 12, 100, 1'b0, drops);
    push_seq(200, 7, 100, 1'b0, drops);
    @(posedge clk);
    #1;
    In1_SEND = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    chk("mid_rst_ack", int'(In1_ACK), 0);
    chk("mid_rst_send", int'(Out1_SEND), 0);
    chk("mid_rst_data", int'(Out1_DATA), 0);
    repeat (2) @(posedge clk);
    #3;
    In1_SEND = 1'b0;
    rdy_mode = 1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    push_seq(100, 12, 100, 1'b0, drops);
    wait_out(12, 200);
    chk("fresh0", got[0], 100);
    chk("fresh1", got[1], 104);
    chk("fresh2", got[2], 108);
    chk("fresh3", got[3], 101);
    repeat (10) @(posedge clk);
    chk("no_stale", got.size(), 12);
    chk("model_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_transpose.md
IMAGE_TRANSPOSE -- requirements
Module: image_transpose

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16, meaning input image width in pixels (≥2).
REQ-002 The block SHALL have parameter IMG_H, default 16, meaning input image height in pixels (≥2).
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 In1_DATA  input  DATA_W  pixel from upstream producer, raster order.
REQ-007 In1_COUNT  input  16  upstream token count, ignored.
REQ-008 In1_SEND  input  1  upstream has a valid pixel on In1_DATA.
REQ-009 In1_ACK  output  1  pixel accepted this cycle.
REQ-010 Out1_DATA  output  DATA_W  transposed pixel.
REQ-011 Out1_COUNT  output  16  constant 16'h0001.
REQ-012 Out1_SEND  output  1  Out1_DATA valid and transferred this cycle.
REQ-013 Out1_RDY  input  1  downstream can accept a pixel this cycle.
REQ-014 Out1_ACK  input  1  downstream acknowledge, ignored (flow control by Out1_RDY only).

Function
REQ-015 An input transfer SHALL occur in a cycle where In1_SEND=1 and In1_ACK=1; In1_ACK SHALL equal In1_SEND AND (write bank not full), combinationally.
REQ-016 An output transfer SHALL occur in a cycle where Out1_SEND=1; Out1_SEND SHALL be 1 only when the output FIFO is non-empty and Out1_RDY=1.
REQ-017 Storage SHALL be two banks (ping-pong) of IMG_W*IMG_H entries, each with a full flag, plus write-bank pointer wb and read-bank pointer rb.
REQ-018 Write side: column counter wc (0..IMG_W-1) and row counter wr (0..IMG_H-1); each input transfer writes bank wb at address wr*IMG_W+wc, then wc increments, wrapping to 0 with wr increment.
REQ-019 On the transfer of pixel (wr=IMG_H-1, wc=IMG_W-1): full[wb]<=1, wb toggles, wc,wr<=0, in the same edge.
REQ-020 Read side: counters rc (0..IMG_W-1, outer) and rr (0..IMG_H-1, inner); a read of bank rb at address rr*IMG_W+rc SHALL be issued when full[rb]=1 and (FIFO occupancy + reads in flight) < 2.
REQ-021 Memory read SHALL be synchronous, one cycle latency; returned data SHALL be pushed into a 2-entry output FIFO driving Out1_DATA from its head.
REQ-022 After each issued read rr increments; at rr=IMG_H-1 it wraps to 0 and rc increments; on issuing address (rr=IMG_H-1, rc=IMG_W-1): full[rb]<=0, rb toggles, counters clear.
REQ-023 Output order SHALL be column-major of the input, i.e. an IMG_H-wide by IMG_W-tall image.
REQ-024 Sustained throughput SHALL be one pixel per cycle on both sides when In1_SEND=1 and Out1_RDY=1 continuously.
REQ-025 Latency: if the last pixel of a frame transfers in cycle T with the read side idle and Out1_RDY=1, the first Out1_SEND of that frame SHALL occur in cycle T+3.
REQ-026 Both banks full SHALL force In1_ACK=0 until the read side frees a bank; a full flag set and a different bank's full flag clear in the same edge SHALL both take effect.
REQ-027 Out1_RDY=0 SHALL hold FIFO contents and Out1_DATA stable; no data SHALL be lost or duplicated.
REQ-028 Out1_COUNT SHALL be 16'h0001 at all times, including during reset.

Reset
REQ-029 RESET=0 SHALL immediately clear: both full flags, wb, rb, all counters, in-flight read, FIFO; In1_ACK=0, Out1_SEND=0, Out1_DATA=0.
REQ-030 Reset mid-frame SHALL discard partial and buffered frames; the first transfer after release is pixel (0,0) of a new frame.
REQ-031 Memory contents need not be reset.

Verification
REQ-032 IMG_W=4, IMG_H=3, input 0..11, Out1_RDY=1 -> output 0,4,8,1,5,9,2,6,10,3,7,11; first Out1_SEND at T+3 after pixel 11's transfer.
REQ-033 Three back-to-back 4x3 frames, In1_SEND and Out1_RDY held 1 -> In1_ACK never drops; 36 outputs, each frame transposed; one output per cycle once streaming.
REQ-034 Out1_RDY=0 throughout, In1_SEND=1 -> exactly 24 transfers accepted then In1_ACK=0; raising Out1_RDY -> In1_ACK returns within 12 outputs + 3 cycles.
REQ-035 Out1_RDY toggled randomly 50% -> output sequence identical to REQ-032 per frame, Out1_DATA stable while Out1_RDY=0.
REQ-036 RESET asserted after 7 pixels of a frame -> outputs 0 immediately; after release, fresh frame 100..111 produces 100,104,108,... with no stale data.
REQ-037 Out1_COUNT checked =1 and In1_COUNT/Out1_ACK randomized with no effect on any output.
